// File: rtl/pn_seq_pkg.sv
// Shared types and defaults for the P/N sequence checker.
// Holds the checker FSM state enum, the default successor map and the
// default counter width, plus a helper that looks up a state's successor.
package pn_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Successor of state s sits at bits [2s+1:2s]: 00->11->01->10->00.
  localparam logic [7:0] NEXT_MAP_DEF = 8'h4B;
  localparam int         CNT_W_DEF    = 8;

  function automatic logic [1:0] next_of(input logic [7:0] map, input logic [1:0] s);
    return map[{s, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/pn_sat_cnt.sv
// Saturating up-counter with synchronous clear, load-to-1 and increment.
// Latency: count visible one clock after the controlling input; no backpressure.
// Ports: clk, reset (async active-low), clr (priority), load (cnt<=1), inc, cnt.
module pn_sat_cnt
  import pn_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= ONE;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/pn_seq_checker.sv
// Checks the sequencer's {A,B} samples against a legal successor map, counts
// legal transitions, reports dwell lengths and latches the first illegal step.
// Latency: all outputs registered, one clock after the sampling edge; no backpressure.
// Ports: clk, reset (async active-low), clr, state_vld, state_in[1:0] in;
//        locked, err, err_sticky, err_from, err_to, trans_cnt,
//        dwell_vld, dwell_state, dwell_len out.
// Build option: define PN_SEQ_DWELL_EN to build the dwell counter and outputs;
// otherwise the three dwell outputs are tied to 0.
module pn_seq_checker
  import pn_seq_pkg::*;
#(
  parameter logic [7:0] NEXT_MAP  = NEXT_MAP_DEF,
  parameter logic [3:0] HOLD_MASK = 4'b0000,
  parameter int         CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             state_vld,
  input  logic [1:0]       state_in,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic [1:0]       err_from,
  output logic [1:0]       err_to,
  output logic [CNT_W-1:0] trans_cnt,
  output logic             dwell_vld,
  output logic [1:0]       dwell_state,
  output logic [CNT_W-1:0] dwell_len
);

  state_t     state, state_nxt;
  logic [1:0] prev;
  logic       smp_arm, smp_legal, smp_hold, smp_bad;

  // Successor match is tested before the hold check, so a self-pointing map
  // entry counts as a transition rather than a hold.
  always_comb begin
    state_nxt = state;
    smp_arm   = 1'b0;
    smp_legal = 1'b0;
    smp_hold  = 1'b0;
    smp_bad   = 1'b0;
    if (clr) begin
      state_nxt = ST_IDLE;
    end else if (state_vld) begin
      case (state)
        ST_IDLE: begin
          smp_arm   = 1'b1;
          state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          smp_legal = (state_in == next_of(NEXT_MAP, prev));
          smp_hold  = !smp_legal && (state_in == prev) && HOLD_MASK[prev];
          smp_bad   = !smp_legal && !smp_hold;
          if (smp_bad) state_nxt = ST_FAULT;
        end
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign locked = (state == ST_TRACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev       <= 2'b00;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_from   <= 2'b00;
      err_to     <= 2'b00;
    end else if (clr) begin
      prev       <= 2'b00;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_from   <= 2'b00;
      err_to     <= 2'b00;
    end else begin
      err <= smp_bad;
      if (smp_arm || smp_legal) prev <= state_in;
      // Only one error can occur before clr, since FAULT ignores samples.
      if (smp_bad) begin
        err_sticky <= 1'b1;
        err_from   <= prev;
        err_to     <= state_in;
      end
    end
  end

  pn_sat_cnt #(.CNT_W(CNT_W)) u_trans_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .load  (1'b0),
    .inc   (smp_legal),
    .cnt   (trans_cnt)
  );

`ifdef PN_SEQ_DWELL_EN
  logic [CNT_W-1:0] dwell;

  // Arming or leaving a state starts the new state's dwell at one sample.
  pn_sat_cnt #(.CNT_W(CNT_W)) u_dwell_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .load  (smp_arm || smp_legal),
    .inc   (smp_hold),
    .cnt   (dwell)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_vld   <= 1'b0;
      dwell_state <= 2'b00;
      dwell_len   <= '0;
    end else if (clr) begin
      dwell_vld   <= 1'b0;
      dwell_state <= 2'b00;
      dwell_len   <= '0;
    end else begin
      dwell_vld <= smp_legal;
      if (smp_legal) begin
        dwell_state <= prev;
        dwell_len   <= dwell;
      end
    end
  end
`else
  assign dwell_vld   = 1'b0;
  assign dwell_state = 2'b00;
  assign dwell_len   = '0;
`endif

endmodule

// File: tb/tb_pn_seq_checker.sv
// Bench for pn_seq_checker: two instances (hold mask 0010 / 8-bit counters,
// and hold mask 1111 / 2-bit counters) share one stimulus stream and are
// compared every cycle against a behavioural model of the checking rules.
module tb_pn_seq_checker;

  localparam logic [7:0] MAP = 8'h4B;
  localparam logic [3:0] HA  = 4'b0010;
  localparam logic [3:0] HB  = 4'b1111;

  logic clk = 1'b0, reset = 1'b0, clr = 1'b0, state_vld = 1'b0;
  logic [1:0] state_in = 2'b00;

  logic       a_locked, a_err, a_err_sticky, a_dwell_vld;
  logic [1:0] a_err_from, a_err_to, a_dwell_state;
  logic [7:0] a_trans_cnt, a_dwell_len;
  logic       b_locked, b_err, b_err_sticky, b_dwell_vld;
  logic [1:0] b_err_from, b_err_to, b_dwell_state;
  logic [1:0] b_trans_cnt, b_dwell_len;

  always #5 clk = ~clk;

  pn_seq_checker #(.NEXT_MAP(MAP), .HOLD_MASK(HA), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .state_vld(state_vld), .state_in(state_in),
    .locked(a_locked), .err(a_err), .err_sticky(a_err_sticky), .err_from(a_err_from),
    .err_to(a_err_to), .trans_cnt(a_trans_cnt), .dwell_vld(a_dwell_vld),
    .dwell_state(a_dwell_state), .dwell_len(a_dwell_len)
  );

  pn_seq_checker #(.NEXT_MAP(MAP), .HOLD_MASK(HB), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .state_vld(state_vld), .state_in(state_in),
    .locked(b_locked), .err(b_err), .err_sticky(b_err_sticky), .err_from(b_err_from),
    .err_to(b_err_to), .trans_cnt(b_trans_cnt), .dwell_vld(b_dwell_vld),
    .dwell_state(b_dwell_state), .dwell_len(b_dwell_len)
  );

  // phase: 0 = waiting for first sample, 1 = tracking, 2 = faulted
  typedef struct {
    int phase; int prev; int dwell; int trans;
    bit err; bit sticky; int efrom; int eto;
    bit dv; int ds; int dl;
  } model_t;

  model_t ma, mb;
  int n_chk = 0, n_fail = 0;
  int err_seen = 0, dv_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic model_t step(input model_t m, input int maxv, input logic [3:0] hmask,
                                  input bit c, input bit v, input int s);
    model_t n;
    int nxt;
    n = m;
    n.err = 1'b0;
    n.dv  = 1'b0;
    if (c) begin
      n = '{default: 0};
      return n;
    end
    if (!v) return n;
    if (m.phase == 0) begin
      n.prev = s; n.dwell = 1; n.phase = 1;
    end else if (m.phase == 1) begin
      nxt = (int'(MAP) >> (2 * m.prev)) % 4;
      if (s == nxt) begin
        n.trans = (m.trans < maxv) ? m.trans + 1 : maxv;
        n.dv = 1'b1; n.ds = m.prev; n.dl = m.dwell;
        n.dwell = 1; n.prev = s;
      end else if (s == m.prev && hmask[m.prev]) begin
        n.dwell = (m.dwell < maxv) ? m.dwell + 1 : maxv;
      end else begin
        n.err = 1'b1; n.sticky = 1'b1; n.efrom = m.prev; n.eto = s; n.phase = 2;
      end
    end
    return n;
  endfunction

  task automatic check_dut(input string p, input model_t e, input logic lk, input logic er,
                           input logic st, input logic [1:0] ef, input logic [1:0] et,
                           input logic [31:0] tc, input logic dv, input logic [1:0] ds,
                           input logic [31:0] dl);
    check({p, "_locked"},     lk, e.phase == 1);
    check({p, "_err"},        er, e.err);
    check({p, "_err_sticky"}, st, e.sticky);
    check({p, "_err_from"},   ef, e.efrom);
    check({p, "_err_to"},     et, e.eto);
    check({p, "_trans_cnt"},  tc, e.trans);
`ifdef PN_SEQ_DWELL_EN
    check({p, "_dwell_vld"},   dv, e.dv);
    check({p, "_dwell_state"}, ds, e.ds);
    check({p, "_dwell_len"},   dl, e.dl);
`else
    check({p, "_dwell_vld"},   dv, 0);
    check({p, "_dwell_state"}, ds, 0);
    check({p, "_dwell_len"},   dl, 0);
`endif
  endtask

  task automatic check_all();
    check_dut("a", ma, a_locked, a_err, a_err_sticky, a_err_from, a_err_to,
              32'(a_trans_cnt), a_dwell_vld, a_dwell_state, 32'(a_dwell_len));
    check_dut("b", mb, b_locked, b_err, b_err_sticky, b_err_from, b_err_to,
              32'(b_trans_cnt), b_dwell_vld, b_dwell_state, 32'(b_dwell_len));
  endtask

  // Drive one cycle from a falling edge, advance the models, check at the next falling edge.
  task automatic run(input bit c, input bit v, input logic [1:0] s);
    clr = c; state_vld = v; state_in = s;
    ma = step(ma, 255, HA, c, v, int'(s));
    mb = step(mb, 3, HB, c, v, int'(s));
    @(negedge clk);
    check_all();
    if (a_err) err_seen++;
    if (a_dwell_vld) dv_seen++;
  endtask

  initial begin
    logic [7:0] mp;
    mp = MAP;
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset state
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;

    // Legal loop 00,11,01,10,00
    run(1'b1, 1'b0, 2'b00);
    err_seen = 0; dv_seen = 0;
    run(1'b0, 1'b1, 2'b00);
    check("t1_locked", a_locked, 1);
    run(1'b0, 1'b1, 2'b11);
    run(1'b0, 1'b1, 2'b01);
    run(1'b0, 1'b1, 2'b10);
    run(1'b0, 1'b1, 2'b00);
    check("t1_trans", 32'(a_trans_cnt), 4);
    check("t1_err_seen", err_seen, 0);
`ifdef PN_SEQ_DWELL_EN
    check("t1_dwell_pulses", dv_seen, 4);
`else
    check("t1_dwell_pulses", dv_seen, 0);
`endif

    // Legal hold on 01 (mask 0010 on dut_a)
    run(1'b1, 1'b0, 2'b00);
    run(1'b0, 1'b1, 2'b00);
    run(1'b0, 1'b1, 2'b11);
    run(1'b0, 1'b1, 2'b01);
    run(1'b0, 1'b1, 2'b01);
    run(1'b0, 1'b1, 2'b01);
    run(1'b0, 1'b1, 2'b10);
    check("t2_trans", 32'(a_trans_cnt), 3);
`ifdef PN_SEQ_DWELL_EN
    check("t2_dwell_vld", a_dwell_vld, 1);
    check("t2_dwell_state", a_dwell_state, 2'b01);
    check("t2_dwell_len", 32'(a_dwell_len), 3);
`endif

    // Illegal 11 -> 00, then FAULT freezes everything
    run(1'b1, 1'b0, 2'b00);
    err_seen = 0;
    run(1'b0, 1'b1, 2'b00);
    run(1'b0, 1'b1, 2'b11);
    run(1'b0, 1'b1, 2'b00);
    check("t3_err", a_err, 1);
    check("t3_err_from", a_err_from, 2'b11);
    check("t3_err_to", a_err_to, 2'b00);
    check("t3_sticky", a_err_sticky, 1);
    run(1'b0, 1'b1, 2'b01);
    run(1'b0, 1'b1, 2'b10);
    check("t3_trans_frozen", 32'(a_trans_cnt), 1);
    check("t3_err_pulses", err_seen, 1);
    check("t3_locked", a_locked, 0);

    // clr together with a sample while in FAULT
    run(1'b1, 1'b1, 2'b00);
    check("t4_sticky", a_err_sticky, 0);
    check("t4_err_from", a_err_from, 0);
    check("t4_trans", 32'(a_trans_cnt), 0);
    check("t4_locked", a_locked, 0);
    run(1'b0, 1'b1, 2'b11);
    check("t4_arm_locked", a_locked, 1);
    check("t4_arm_trans", 32'(a_trans_cnt), 0);

    // dut_b: 2-bit counters saturate at 3
    run(1'b1, 1'b0, 2'b00);
    run(1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) run(1'b0, 1'b1, 2'b00);
    run(1'b0, 1'b1, 2'b11);
`ifdef PN_SEQ_DWELL_EN
    check("t5_dwell_sat", 32'(b_dwell_len), 3);
`endif
    run(1'b0, 1'b1, 2'b01);
    run(1'b0, 1'b1, 2'b10);
    run(1'b0, 1'b1, 2'b00);
    run(1'b0, 1'b1, 2'b11);
    check("t5_trans_sat", 32'(b_trans_cnt), 3);

    // Asynchronous reset between clock edges
    run(1'b1, 1'b0, 2'b00);
    run(1'b0, 1'b1, 2'b00);
    run(1'b0, 1'b1, 2'b11);
    run(1'b0, 1'b1, 2'b01);
    state_vld = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6_locked", a_locked, 0);
    check("t6_trans_a", 32'(a_trans_cnt), 0);
    check("t6_trans_b", 32'(b_trans_cnt), 0);
    check("t6_dwell_len", 32'(a_dwell_len), 0);
    ma = '{default: 0};
    mb = '{default: 0};
    @(negedge clk);
    check_all();
    reset = 1'b1;
    run(1'b0, 1'b1, 2'b01);
    check("t6_rearm_trans", 32'(a_trans_cnt), 0);
    check("t6_rearm_locked", a_locked, 1);
    run(1'b0, 1'b1, 2'b10);
    check("t6_after_trans", 32'(a_trans_cnt), 1);

    // Randomized stream biased toward legal steps
    for (int i = 0; i < 400; i++) begin
      int r;
      bit c, v;
      logic [1:0] s;
      r = $urandom_range(0, 99);
      c = 1'b0;
      v = 1'b1;
      s = 2'($urandom_range(0, 3));
      if (r < 3 || (ma.phase == 2 && r < 25)) begin
        c = 1'b1;
        v = 1'($urandom_range(0, 1));
      end else if (r < 15) begin
        v = 1'b0;
      end else if (r < 75) begin
        s = mp[2*ma.prev +: 2];
      end else if (r < 85) begin
        s = 2'(ma.prev);
      end
      run(c, v, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
